sdram_write_fifo: RTL and testbench

Upstream feeder for the SDRAM write stage. Accepts Wishbone slave write cycles, packs each 32-bit write and its byte selects into a 36-bit {mask, data} entry, and buffers the entries in a first-word-fall-through FIFO. It also drives the write stage's `en` and `address` inputs so that each run of address-contiguous writes becomes one SDRAM write burst.

---
 rtl/sdram_write_fifo.sv | 130 +++++++++++++
 tb/tb_sdram_write_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_write_fifo.sv
// rtl/sdram_write_fifo.sv - Wishbone write buffer feeding the SDRAM write stage as contiguous bursts
module sdram_write_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic        wb_ack,
    output logic        write_en,
    output logic [21:0] write_address,
    input  logic        write_ready,
    output logic [35:0] fifo_data,
    output logic        fifo_empty,
    input  logic        fifo_rd,
    output logic        fifo_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, RELEASE} state_t;
    state_t state;

    logic [35:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic [21:0]           nxt;
    logic                  nxt_wrap;

    logic [21:0] wadr;
    logic [35:0] entry;
    logic        req;
    logic        contig;
    logic        accept;
    logic        pop;
    logic        unused_bits;

    assign wadr        = {wb_adr[22:2], 1'b0};
    assign entry       = {~wb_sel[1], ~wb_sel[0], ~wb_sel[3], ~wb_sel[2], wb_dat_i};
    assign req         = wb_cyc & wb_stb & wb_we & ~wb_ack;
    // A wrapped next address never counts as a continuation of the burst
    assign contig      = (wadr == nxt) & ~nxt_wrap;
    assign pop         = fifo_rd & ~fifo_empty;
    assign unused_bits = ^{wb_adr[31:23], wb_adr[1:0]};

    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE:    accept = req & write_ready & ~fifo_full;
            BURST:   accept = req & contig & ~fifo_full;
            default: accept = 1'b0;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (accept && !pop)
            count_nxt = count + 1'b1;
        else if (!accept && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= entry;
    end

    assign fifo_data = fifo_empty ? 36'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wb_ack        <= 1'b0;
            write_en      <= 1'b0;
            write_address <= 22'd0;
            nxt           <= 22'd0;
            nxt_wrap      <= 1'b0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
        end else begin
            wb_ack     <= accept;
            count      <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == FULL_COUNT);
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        write_address    <= wadr;
                        {nxt_wrap, nxt}  <= {1'b0, wadr} + 23'd2;
                        write_en         <= 1'b1;
                        state            <= BURST;
                    end
                end
                BURST: begin
                    if (accept)
                        {nxt_wrap, nxt} <= {1'b0, nxt} + 23'd2;
                    else if (!wb_cyc || (req && !contig))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        write_en <= 1'b0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (write_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_write_fifo.sv
// tb/tb_sdram_write_fifo.sv - scoreboard bench for sdram_write_fifo
module tb_sdram_write_fifo;
    localparam int DL2 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_i;
    logic        wb_ack;
    logic        write_en;
    logic [21:0] write_address;
    logic        write_ready;
    logic [35:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        fifo_full;

    sdram_write_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
        .write_en(write_en), .write_address(write_address), .write_ready(write_ready),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] badr;
        logic [35:0] ent;
    } exp_t;

    exp_t        expq[$];
    int          n_total = 0;
    int          n_pass  = 0;
    bit          pop_en  = 0;
    bit          rdy_rand = 0;
    bit          seq_first = 1;
    bit          saw_low = 0;
    logic [21:0] prev_wadr = '0;
    logic [21:0] cur_burst = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write-stage side: pops at random and checks each popped head
    initial begin
        exp_t e;
        fifo_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!write_en)
                saw_low = 1;
            if (rst || !pop_en) begin
                fifo_rd = 1'b0;
            end else if (fifo_empty) begin
                fifo_rd = ($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 2) != 0) begin
                if (expq.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("pop_data", fifo_data, e.ent);
                    chk("pop_address", write_address, e.badr);
                    chk("pop_write_en", write_en, 1);
                end
                fifo_rd = 1'b1;
            end else begin
                fifo_rd = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rdy_rand)
                write_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wb_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                            input int budget, output bit acked, output int cycles);
        logic [21:0] wadr;
        exp_t        e;
        wadr = {adr[22:2], 1'b0};
        wb_cyc = 1; wb_stb = 1; wb_we = 1;
        wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
        acked = 0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (wb_ack) begin
                acked = 1;
                cycles = i;
                break;
            end
        end
        if (acked) begin
            wb_stb = 0;
            if (seq_first || (({1'b0, prev_wadr} + 23'd2) != {1'b0, wadr}))
                cur_burst = wadr;
            seq_first = 0;
            prev_wadr = wadr;
            e.badr = cur_burst;
            e.ent  = {~sel[1], ~sel[0], ~sel[3], ~sel[2], dat};
            expq.push_back(e);
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                      output int cycles);
        bit acked;
        wb_write(adr, sel, dat, 200, acked, cycles);
        chk("ack_timeout", acked, 1);
    endtask

    task automatic end_seq(input int gap);
        wb_cyc = 0; wb_stb = 0;
        seq_first = 1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic drain_wait();
        bit done;
        done = 0;
        pop_en = 1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (expq.size() == 0 && fifo_empty && !write_en) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", done, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int          cyc;
        bit          acked;
        logic [31:0] adr;
        int          len;

        rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat_i = 0;
        write_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", wb_ack, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_write_address", write_address, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_fifo_data", fifo_data, 0);
        rst = 0;
        @(posedge clk); #1;

        // single write, then release held off by write_ready
        wr(32'h0000_0100, 4'b1111, 32'hDEADBEEF, cyc);
        chk("single_ack_latency", cyc, 0);
        chk("single_write_address", write_address, 22'h080);
        chk("single_write_en", write_en, 1);
        chk("single_fifo_data", fifo_data, 36'h0_DEADBEEF);
        @(posedge clk); #1;
        chk("single_ack_one_cycle", wb_ack, 0);
        write_ready = 0;
        end_seq(1);
        drain_wait();
        wb_write(32'h0000_0300, 4'b0110, 32'h1234_5678, 5, acked, cyc);
        chk("release_stall_noack", acked, 0);
        chk("release_write_en_low", write_en, 0);
        write_ready = 1;
        wb_write(32'h0000_0300, 4'b0110, 32'h1234_5678, 50, acked, cyc);
        chk("release_then_ack", acked, 1);
        chk("mask_bits", fifo_data[35:32], 4'b0110);
        end_seq(1);
        drain_wait();

        // four contiguous writes form one burst
        for (int i = 0; i < 4; i++) begin
            wr(32'h200 + 32'(4 * i), 4'b1111, $urandom, cyc);
            chk("contig_write_en", write_en, 1);
            chk("contig_write_address", write_address, 22'h100);
        end
        end_seq(1);
        drain_wait();

        // fill the FIFO: fifth write stalls until a pop
        pop_en = 0;
        for (int i = 0; i < 4; i++)
            wr(32'h1000 + 32'(4 * i), 4'b1111, $urandom, cyc);
        wb_write(32'h1010, 4'b1111, 32'h5555_AAAA, 6, acked, cyc);
        chk("full_stall_noack", acked, 0);
        chk("full_flag", fifo_full, 1);
        pop_en = 1;
        wb_write(32'h1010, 4'b1111, 32'h5555_AAAA, 50, acked, cyc);
        chk("full_then_ack", acked, 1);
        end_seq(1);
        drain_wait();

        // non-contiguous write waits for drain and starts a new burst
        wr(32'h400, 4'b1111, 32'hCAFE_0001, cyc);
        saw_low = 0;
        wr(32'h800, 4'b1111, 32'hCAFE_0002, cyc);
        chk("nc_write_en_low_seen", saw_low, 1);
        chk("nc_first_drained", expq.size(), 1);
        chk("nc_new_address", write_address, 22'h400);
        end_seq(1);
        drain_wait();

        // reset in the middle of a burst
        pop_en = 0;
        for (int i = 0; i < 3; i++)
            wr(32'h3000 + 32'(4 * i), 4'b1111, $urandom, cyc);
        wb_cyc = 0; wb_stb = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("midrst_fifo_empty", fifo_empty, 1);
        chk("midrst_write_en", write_en, 0);
        chk("midrst_ack", wb_ack, 0);
        chk("midrst_fifo_full", fifo_full, 0);
        expq.delete();
        seq_first = 1;
        pop_en = 1;
        wr(32'h5000, 4'b0011, 32'h0BAD_F00D, cyc);
        chk("midrst_idle_accept", cyc, 0);
        end_seq(1);
        drain_wait();

        // randomized sequences with random pops and write_ready
        rdy_rand = 1;
        for (int s = 0; s < 40; s++) begin
            adr = ($urandom_range(0, 7) == 0) ? (32'h007F_FFF0 | 32'($urandom_range(0, 3) * 4)) : $urandom;
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                wr(adr, 4'($urandom), $urandom, cyc);
                adr = ($urandom_range(0, 3) != 0) ? adr + 32'd4 : $urandom;
            end
            end_seq($urandom_range(1, 3));
        end
        rdy_rand = 0;
        write_ready = 1;
        drain_wait();
        chk("final_queue_empty", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
